// File: rtl/usr_pkg.sv
`default_nettype none
// ============================================================================
// Module   : usr_pkg
// Brief    : Shared types and bit-order constants for the universal shift
//            register and its serial receive end (sipo_deserializer).
// Revision : 1.0 - initial release
// ============================================================================
package usr_pkg;

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    localparam logic DIR_MSB_FIRST = 1'b0;
    localparam logic DIR_LSB_FIRST = 1'b1;

    typedef enum logic [1:0] {
        OP_HOLD = 2'd0,
        OP_LOAD = 2'd1,
        OP_SHL  = 2'd2,
        OP_SHR  = 2'd3
    } shift_op_t;

endpackage : usr_pkg
`default_nettype wire

// File: rtl/sipo_deserializer_if.sv
`default_nettype none
// ============================================================================
// Module   : sipo_deserializer_if
// Brief    : Serial link input and parallel word output of the deserializer.
// Revision : 1.0 - initial release
// ============================================================================
interface sipo_deserializer_if #(
    parameter int WIDTH = 4
);
    logic             SIN;
    logic             SVALID;
    logic             SOF;
    logic             DIR;
    logic [WIDTH-1:0] DATAOUT;
    logic             DVALID;
    logic             BUSY;
    logic             ERR;

    modport master (
        output SIN, SVALID, SOF, DIR,
        input  DATAOUT, DVALID, BUSY, ERR
    );

    modport slave (
        input  SIN, SVALID, SOF, DIR,
        output DATAOUT, DVALID, BUSY, ERR
    );
endinterface : sipo_deserializer_if
`default_nettype wire

// File: rtl/sipo_shift_core.sv
`default_nettype none
// ============================================================================
// Module   : sipo_shift_core
// Brief    : WIDTH-bit shift register with hold / load-first / left / right.
// Revision : 1.0 - initial release
// ============================================================================
module sipo_shift_core
    import usr_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  wire logic             clk,
    input  wire logic             rst,
    input  shift_op_t             i_op,
    input  wire logic             i_din,
    input  wire logic             i_dir,
    output logic [WIDTH-1:0]      o_next
);

    logic [WIDTH-1:0] r_q;

    // o_next exposes the post-edge value so the word can be captured on the last bit
    always_comb begin
        o_next = r_q;
        case (i_op)
            OP_LOAD: o_next = (i_dir == DIR_LSB_FIRST) ? {i_din, {(WIDTH-1){1'b0}}}
                                                       : {{(WIDTH-1){1'b0}}, i_din};
            OP_SHL:  o_next = {r_q[WIDTH-2:0], i_din};
            OP_SHR:  o_next = {i_din, r_q[WIDTH-1:1]};
            default: o_next = r_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_q <= '0;
        end else begin
            r_q <= o_next;
        end
    end

endmodule : sipo_shift_core
`default_nettype wire

// File: rtl/sipo_deserializer.sv
`default_nettype none
// ============================================================================
// Module   : sipo_deserializer
// Brief    : Framed serial-in, parallel-out receiver with selectable bit order.
// Revision : 1.0 - initial release
// ============================================================================
module sipo_deserializer
    import usr_pkg::*;
#(
    parameter int WIDTH = 4,
    parameter int CNTW  = $clog2(WIDTH)
) (
    input  wire logic          clock,
    input  wire logic          reset,
    sipo_deserializer_if.slave bus
);

    localparam logic [CNTW-1:0] c_LAST = CNTW'(WIDTH - 1);
    localparam logic [CNTW-1:0] c_ONE  = CNTW'(1);

    state_t            r_state;
    state_t            w_state_next;
    logic [CNTW-1:0]   r_count;
    logic [CNTW-1:0]   w_count_next;
    logic              r_dir;
    logic              w_dir_next;
    logic [WIDTH-1:0]  r_dataout;
    logic              r_dvalid;
    logic              r_err;
    logic              w_dvalid_next;
    logic              w_err_next;
    logic              w_complete;
    shift_op_t         w_op;
    logic [WIDTH-1:0]  w_shift_next;

    sipo_shift_core #(
        .WIDTH (WIDTH)
    ) u_core (
        .clk    (clock),
        .rst    (reset),
        .i_op   (w_op),
        .i_din  (bus.SIN),
        .i_dir  (bus.DIR),
        .o_next (w_shift_next)
    );

    always_comb begin
        w_state_next  = r_state;
        w_count_next  = r_count;
        w_dir_next    = r_dir;
        w_op          = OP_HOLD;
        w_dvalid_next = 1'b0;
        w_err_next    = 1'b0;
        w_complete    = 1'b0;
        case (r_state)
            IDLE: begin
                if (bus.SVALID && bus.SOF) begin
                    w_op         = OP_LOAD;
                    w_dir_next   = bus.DIR;
                    w_count_next = c_ONE;
                    w_state_next = SHIFT;
                end
            end
            SHIFT: begin
                if (bus.SVALID && bus.SOF) begin
                    // Premature start: drop the partial word and restart on this bit
                    w_err_next   = 1'b1;
                    w_op         = OP_LOAD;
                    w_dir_next   = bus.DIR;
                    w_count_next = c_ONE;
                end else if (bus.SVALID) begin
                    w_op = (r_dir == DIR_LSB_FIRST) ? OP_SHR : OP_SHL;
                    if (r_count == c_LAST) begin
                        w_complete    = 1'b1;
                        w_dvalid_next = 1'b1;
                        w_count_next  = '0;
                        w_state_next  = IDLE;
                    end else begin
                        w_count_next = r_count + c_ONE;
                    end
                end
            end
            default: w_state_next = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state   <= IDLE;
            r_count   <= '0;
            r_dir     <= DIR_MSB_FIRST;
            r_dataout <= '0;
            r_dvalid  <= 1'b0;
            r_err     <= 1'b0;
        end else begin
            r_state  <= w_state_next;
            r_count  <= w_count_next;
            r_dir    <= w_dir_next;
            r_dvalid <= w_dvalid_next;
            r_err    <= w_err_next;
            if (w_complete) begin
                r_dataout <= w_shift_next;
            end
        end
    end

    assign bus.DATAOUT = r_dataout;
    assign bus.DVALID  = r_dvalid;
    assign bus.ERR     = r_err;
    assign bus.BUSY    = (r_state == SHIFT);

endmodule : sipo_deserializer
`default_nettype wire

// File: tb/tb_sipo_deserializer.sv
`default_nettype none
// ============================================================================
// Module   : tb_sipo_deserializer
// Brief    : Directed + random bench with a bit-queue reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_sipo_deserializer;

    localparam int W = 4;

    logic clock = 1'b0;
    logic reset = 1'b1;

    sipo_deserializer_if #(.WIDTH(W)) bus_if();

    sipo_deserializer #(.WIDTH(W)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus_if)
    );

    always #5 clock = ~clock;

    int n_checks = 0;
    int n_fail   = 0;

    function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endfunction

    // Reference model: the frame is a queue of received bits
    bit           m_live = 1'b0;
    bit           m_in_frame;
    bit           m_bits[$];
    bit           m_dir;
    logic [W-1:0] m_data;
    bit           m_dv;
    bit           m_err;
    int           cyc = 0;
    int           dv_count = 0;
    int           err_count = 0;
    int           dv_cyc[$];

    function automatic logic [W-1:0] assemble();
        logic [W-1:0] r;
        r = '0;
        for (int i = 0; i < W; i++) begin
            if (m_dir == 1'b0) r[W-1-i] = m_bits[i];
            else               r[i]     = m_bits[i];
        end
        return r;
    endfunction

    always @(posedge clock) begin
        logic s_rst, s_sv, s_sof, s_sin, s_dir;
        s_rst = reset;
        s_sv  = bus_if.SVALID;
        s_sof = bus_if.SOF;
        s_sin = bus_if.SIN;
        s_dir = bus_if.DIR;
        cyc++;
        m_dv  = 1'b0;
        m_err = 1'b0;
        if (s_rst) begin
            m_live     = 1'b1;
            m_in_frame = 1'b0;
            m_bits.delete();
            m_dir      = 1'b0;
            m_data     = '0;
        end else if (s_sv === 1'b1) begin
            if (s_sof) begin
                m_err      = m_in_frame;
                m_bits.delete();
                m_bits.push_back(s_sin);
                m_dir      = s_dir;
                m_in_frame = 1'b1;
            end else if (m_in_frame) begin
                m_bits.push_back(s_sin);
                if (m_bits.size() == W) begin
                    m_data     = assemble();
                    m_dv       = 1'b1;
                    m_in_frame = 1'b0;
                end
            end
        end
        #1;
        if (m_live) begin
            check("dataout", 32'(bus_if.DATAOUT), 32'(m_data));
            check("dvalid",  32'(bus_if.DVALID),  32'(m_dv));
            check("busy",    32'(bus_if.BUSY),    32'(m_in_frame));
            check("err",     32'(bus_if.ERR),     32'(m_err));
            if (bus_if.DVALID === 1'b1) begin
                dv_count++;
                dv_cyc.push_back(cyc);
            end
            if (bus_if.ERR === 1'b1) err_count++;
        end
    end

    task automatic tick(input logic sv, input logic sof, input logic sin, input logic dir);
        bus_if.SVALID = sv;
        bus_if.SOF    = sof;
        bus_if.SIN    = sin;
        bus_if.DIR    = dir;
        @(posedge clock);
        #2;
    endtask

    task automatic idle();
        tick(1'b0, 1'b0, 1'bx, 1'b0);
    endtask

    initial begin
        int dv0;
        int er0;
        bus_if.SVALID = 1'b0;
        bus_if.SOF    = 1'b0;
        bus_if.SIN    = 1'b0;
        bus_if.DIR    = 1'b0;

        reset = 1'b1;
        idle();
        idle();
        reset = 1'b0;
        idle();
        check("rst_dataout", 32'(bus_if.DATAOUT), 32'h0);
        check("rst_dvalid",  32'(bus_if.DVALID),  32'h0);
        check("rst_busy",    32'(bus_if.BUSY),    32'h0);
        check("rst_err",     32'(bus_if.ERR),     32'h0);

        // MSB-first 1,0,1,1
        tick(1, 1, 1, 0);
        check("msb_busy_b1", 32'(bus_if.BUSY), 32'h1);
        tick(1, 0, 0, 1);
        tick(1, 0, 1, 1);
        tick(1, 0, 1, 0);
        check("msb_data",   32'(bus_if.DATAOUT), 32'hB);
        check("msb_dvalid", 32'(bus_if.DVALID),  32'h1);
        check("msb_busy",   32'(bus_if.BUSY),    32'h0);
        idle();
        check("msb_dv_once", 32'(bus_if.DVALID), 32'h0);

        // LSB-first 1,0,1,1 then back-to-back MSB-first 0,1,1,0
        tick(1, 1, 1, 1);
        tick(1, 0, 0, 0);
        tick(1, 0, 1, 0);
        tick(1, 0, 1, 0);
        check("lsb_data", 32'(bus_if.DATAOUT), 32'hD);
        tick(1, 1, 0, 0);
        tick(1, 0, 1, 1);
        tick(1, 0, 1, 1);
        tick(1, 0, 0, 1);
        check("b2b_data", 32'(bus_if.DATAOUT), 32'h6);
        check("b2b_gap",  32'(dv_cyc[dv_cyc.size()-1] - dv_cyc[dv_cyc.size()-2]), 32'd4);

        // MSB-first 1,1,0,1 with a 3-cycle stall before the last bit
        tick(1, 1, 1, 0);
        tick(1, 0, 1, 0);
        tick(1, 0, 0, 0);
        dv0 = dv_count;
        for (int i = 0; i < 3; i++) idle();
        check("stall_hold", 32'(bus_if.DATAOUT), 32'h6);
        check("stall_nodv", 32'(dv_count - dv0), 32'd0);
        check("stall_busy", 32'(bus_if.BUSY), 32'h1);
        tick(1, 0, 1, 0);
        check("stall_data", 32'(bus_if.DATAOUT), 32'hD);

        // Premature start
        dv0 = dv_count;
        er0 = err_count;
        tick(1, 1, 1, 0);
        tick(1, 0, 0, 0);
        tick(1, 1, 0, 0);
        check("pre_err", 32'(bus_if.ERR), 32'h1);
        check("pre_hold", 32'(bus_if.DATAOUT), 32'hD);
        tick(1, 0, 1, 0);
        check("pre_err_once", 32'(bus_if.ERR), 32'h0);
        tick(1, 0, 1, 0);
        tick(1, 0, 0, 0);
        check("pre_data",  32'(bus_if.DATAOUT), 32'h6);
        check("pre_dvcnt", 32'(dv_count - dv0), 32'd1);
        check("pre_errcnt", 32'(err_count - er0), 32'd1);

        // Stray bits in IDLE, then reset mid-frame
        tick(1, 0, 1, 0);
        tick(1, 0, 1, 0);
        check("stray_busy", 32'(bus_if.BUSY), 32'h0);
        check("stray_data", 32'(bus_if.DATAOUT), 32'h6);
        dv0 = dv_count;
        tick(1, 1, 1, 0);
        tick(1, 0, 1, 0);
        reset = 1'b1;
        idle();
        reset = 1'b0;
        check("mid_rst_data", 32'(bus_if.DATAOUT), 32'h0);
        check("mid_rst_busy", 32'(bus_if.BUSY),    32'h0);
        check("mid_rst_nodv", 32'(dv_count - dv0), 32'd0);
        idle();

        // Randomized traffic against the model
        for (int i = 0; i < 600; i++) begin
            logic sv;
            reset = ($urandom_range(0, 149) == 0);
            sv    = ($urandom_range(0, 9) < 7);
            tick(sv, ($urandom_range(0, 5) == 0), sv ? 1'($urandom) : 1'bx, 1'($urandom));
        end
        reset = 1'b0;
        for (int i = 0; i < 4; i++) idle();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule : tb_sipo_deserializer
`default_nettype wire

// File: doc/sipo_deserializer.md
Name: sipo_deserializer

Overview:
- Serial-in, parallel-out receiver. It is the receive end of the serial link that our universal shift register drives in shift mode.
- Assembles a framed serial bitstream into WIDTH-bit words.
- Bit order is selectable per frame.
- Reports each completed word with a one-cycle valid strobe and flags framing errors.
- Sits between a serial link input and a parallel consumer. Output words are held stable until the next word completes.

Parameters:
- WIDTH, 4, word width in bits; legal range 2..32.
- CNTW, $clog2(WIDTH), bit-counter width.

Ports:
- clock  input  1  single system clock; all logic on the rising edge.
- reset  input  1  synchronous, active-high reset.
- SIN  input  1  serial data bit.
- SVALID  input  1  qualifies SIN; a bit is consumed only on an edge where SVALID=1.
- SOF  input  1  start of frame; meaningful only when SVALID=1; marks the current SIN as bit 0 of a new word.
- DIR  input  1  bit order, sampled only with the SOF bit:
  - 0 = MSB-first: shift left, new bit into bit 0.
  - 1 = LSB-first: shift right, new bit into bit WIDTH-1.
- DATAOUT  output  WIDTH  last completed word; holds until the next completion.
- DVALID  output  1  one-cycle pulse; DATAOUT is new this cycle.
- BUSY  output  1  high while a frame is partially received.
- ERR  output  1  one-cycle pulse on a framing error.

Behaviour:
- Clock and reset:
  - One clock; reset is synchronous and active-high.
  - On reset: DATAOUT=0, DVALID=0, BUSY=0, ERR=0; shift register=0; count=0; state=IDLE; latched DIR=0.
- States:
  - IDLE: BUSY=0.
    - SVALID&SOF: load first bit into the shift register per DIR, latch DIR, count=1, go to SHIFT.
    - SVALID without SOF: bit discarded, no output change.
  - SHIFT: BUSY=1.
    - SVALID=0: hold everything (stall, no timeout).
    - SVALID&~SOF: shift in SIN using the latched DIR, count+1.
      - If this is bit WIDTH-1: DATAOUT takes the full assembled word and DVALID=1, both registered on that edge. Count=0 and state returns to IDLE.
    - SVALID&SOF (premature start): ERR=1 for one cycle and the partial word is discarded. The current bit restarts a frame (first bit, new DIR latched, count=1). Stay in SHIFT; DATAOUT is unchanged.
- Latency: DATAOUT/DVALID are updated on the same edge that samples the last bit, so they are visible in the cycle after the last bit is presented.
- Back-to-back frames: SOF in the cycle right after the last bit starts a new frame normally.
  - DVALID (old word) and BUSY (new frame) are both high in that cycle.
- Word assembly:
  - MSB-first stream b0..b(W-1) yields DATAOUT={b0,...,b(W-1)}.
  - LSB-first yields DATAOUT={b(W-1),...,b0}.
- DIR changes mid-frame are ignored.
- DVALID and ERR never assert in the same cycle.
- Count never exceeds WIDTH-1; no wrap inside a frame.
- Reset mid-frame: partial word dropped, no DVALID, DATAOUT cleared to 0.
- X on SIN while SVALID=0 must not propagate.

Decomposition:
- Shared package usr_pkg:
  - state enum IDLE/SHIFT;
  - DIR_MSB_FIRST=1'b0 and DIR_LSB_FIRST=1'b1 constants.
  - These are shared with the universal shift register's mode constants.
- One sub-module, sipo_shift_core: WIDTH-bit shift register with load-first, shift-left and shift-right controls plus hold.
- The FSM, counter and output registers stay in the top level.

Test Plan (WIDTH=4, 10 ns clock):
- Reset held 2 cycles, then released with SVALID=0 -> DATAOUT=0000, DVALID=0, BUSY=0, ERR=0.
- MSB-first SOF+1,0,1,1 on consecutive cycles -> DATAOUT=1011, DVALID high exactly 1 cycle, BUSY high for bits 1..3.
- LSB-first (DIR=1) SOF+1,0,1,1 -> DATAOUT=1101; then an immediate back-to-back MSB-first frame 0,1,1,0 -> DATAOUT=0110, two DVALID pulses 4 cycles apart.
- MSB-first 1,1,0,1 with SVALID low for 3 cycles between bits 2 and 3 -> DATAOUT=1101; it stays at the previous value and DVALID stays 0 during the stall.
- Premature start: SOF+1,0, then SOF+0,1,1,0 MSB-first -> ERR pulse once at the second SOF, no DVALID for the partial word, then DATAOUT=0110.
- Stray bits 1,1 without SOF in IDLE -> ignored, BUSY=0. Then SOF+1,1 and reset asserted before the frame completes -> DATAOUT=0000, BUSY=0, no DVALID.
